// File: rtl/register_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// pending scoreboard that gives decode its RAW-hazard stall information.
module register_file_mp #(
   parameter int              XLEN     = 32,
   parameter int              NUM_REGS = 32,
   parameter int              NUM_RD   = 2,
   parameter int              SP_INDEX = 2,
   parameter logic [XLEN-1:0] SP_RESET = 32'h01000000,
   localparam int             AW       = $clog2(NUM_REGS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_RD*AW-1:0]   rs_addr,
   output logic [NUM_RD*XLEN-1:0] rs_data,
   output logic [NUM_RD-1:0]      rs_busy,
   input  logic                   wb0_enable,
   input  logic [AW-1:0]          wb0_rd,
   input  logic [XLEN-1:0]        wb0_data,
   input  logic                   wb1_enable,
   input  logic [AW-1:0]          wb1_rd,
   input  logic [XLEN-1:0]        wb1_data,
   input  logic                   issue_valid,
   input  logic [AW-1:0]          issue_rd,
   input  logic                   flush
);

   logic [XLEN-1:0]     regs_r      [NUM_REGS];
   logic [XLEN-1:0]     regs_next_s [NUM_REGS];
   logic [NUM_REGS-1:0] pending_r;
   logic [NUM_REGS-1:0] pending_next_s;
   logic [AW-1:0]       rd_addr_s   [NUM_RD];

   // Next-state register contents and pending bits; reads sample this same
   // next state, which gives the bypass priority (WB1 over WB0 over storage).
   always_comb begin
      regs_next_s    = regs_r;
      pending_next_s = pending_r;
      for (int i = 32'sd0; i < NUM_REGS; i++) begin
         if (i == 32'sd0) begin
            regs_next_s[i]    = {XLEN{1'b0}};
            pending_next_s[i] = 1'b0;
         end else begin
            if (wb1_enable && (wb1_rd == AW'(i))) begin
               regs_next_s[i] = wb1_data;
            end else if (wb0_enable && (wb0_rd == AW'(i))) begin
               regs_next_s[i] = wb0_data;
            end else begin
               regs_next_s[i] = regs_r[i];
            end
            // A new producer issuing this cycle owns the register even if
            // the old value is being written back or the pipe is flushed.
            if (issue_valid && (issue_rd == AW'(i))) begin
               pending_next_s[i] = 1'b1;
            end else if (flush || (wb0_enable && (wb0_rd == AW'(i))) ||
                         (wb1_enable && (wb1_rd == AW'(i)))) begin
               pending_next_s[i] = 1'b0;
            end else begin
               pending_next_s[i] = pending_r[i];
            end
         end
      end
   end

   // Split the packed read-address bus into per-port addresses.
   always_comb begin
      for (int k = 32'sd0; k < NUM_RD; k++) begin
         rd_addr_s[k] = rs_addr[k*AW +: AW];
      end
   end

   // Architectural storage and scoreboard state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 32'sd0; i < NUM_REGS; i++) begin
            regs_r[i] <= (i == SP_INDEX) ? SP_RESET : {XLEN{1'b0}};
         end
         pending_r <= {NUM_REGS{1'b0}};
      end else begin
         regs_r    <= regs_next_s;
         pending_r <= pending_next_s;
      end
   end

   // Registered read ports: data and busy reflect the post-edge state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rs_data <= {(NUM_RD*XLEN){1'b0}};
         rs_busy <= {NUM_RD{1'b0}};
      end else begin
         for (int k = 32'sd0; k < NUM_RD; k++) begin
            rs_data[k*XLEN +: XLEN] <= regs_next_s[rd_addr_s[k]];
            rs_busy[k]              <= pending_next_s[rd_addr_s[k]];
         end
      end
   end

endmodule
